// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: IF-stage BHT/BTB lookup, EX-stage misprediction
// resolution with PC redirect and pipeline flush, table training and
// resolved/mispredicted statistics.
module branch_predict_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_BITS    = 2,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned TAG_W       = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_IF,
  output logic            pred_taken_IF,
  output logic [XLEN-1:0] pred_target_IF,
  input  logic [6:0]      op_ex,
  input  logic            stall_EX,
  input  logic [XLEN-1:0] pc_EX,
  input  logic            taken_EX,
  input  logic [XLEN-1:0] target_EX,
  input  logic            pred_taken_EX,
  input  logic [XLEN-1:0] pred_target_EX,
  output logic            comp_o,
  output logic            flush_IF_ID,
  output logic            flush_ID_EX,
  output logic [XLEN-1:0] PC_jump_EX,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int unsigned BHT_IDX = $clog2(BHT_ENTRIES);
  localparam int unsigned BTB_IDX = $clog2(BTB_ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [CNT_BITS-1:0] bht        [BHT_ENTRIES];
  logic                btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]    btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]     btb_target [BTB_ENTRIES];

  logic [BHT_IDX-1:0] if_bht_idx, ex_bht_idx;
  logic [BTB_IDX-1:0] if_btb_idx, ex_btb_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;
  logic               if_hit;
  logic               res, act_taken, mismatch;
  logic [CNT_BITS-1:0] ex_cnt;

  assign if_bht_idx = pc_IF[BHT_IDX+1:2];
  assign if_btb_idx = pc_IF[BTB_IDX+1:2];
  assign if_tag     = pc_IF[TAG_W+BTB_IDX+1:BTB_IDX+2];
  assign ex_bht_idx = pc_EX[BHT_IDX+1:2];
  assign ex_btb_idx = pc_EX[BTB_IDX+1:2];
  assign ex_tag     = pc_EX[TAG_W+BTB_IDX+1:BTB_IDX+2];
  assign ex_cnt     = bht[ex_bht_idx];

  // IF-stage lookup: reads the registered tables, so a same-cycle update is not yet visible
  always_comb begin
    if_hit         = btb_valid[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);
    pred_taken_IF  = !rst && if_hit && bht[if_bht_idx][CNT_BITS-1];
    pred_target_IF = pred_taken_IF ? btb_target[if_btb_idx] : pc_IF + XLEN'(4);
  end

  // EX-stage resolution: direction/target compare and redirect
  always_comb begin
    act_taken   = taken_EX || (op_ex == OP_JAL) || (op_ex == OP_JALR);
    res         = (op_ex[6:4] == 3'b110) && !stall_EX && !rst;
    mismatch    = (pred_taken_EX != act_taken) ||
                  (act_taken && (pred_target_EX != target_EX));
    comp_o      = res && mismatch;
    flush_IF_ID = comp_o;
    flush_ID_EX = comp_o;
    PC_jump_EX  = (act_taken && !rst) ? target_EX : pc_EX + XLEN'(4);
  end

  // Table training and statistics; reset wins over any update pending that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_WNT;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
      br_count      <= '0;
      mispred_count <= '0;
    end else if (res) begin
      if (act_taken) begin
        if (ex_cnt != CNT_MAX) bht[ex_bht_idx] <= ex_cnt + CNT_BITS'(1);
        btb_valid[ex_btb_idx]  <= 1'b1;
        btb_tag[ex_btb_idx]    <= ex_tag;
        btb_target[ex_btb_idx] <= target_EX;
      end else if (ex_cnt != '0) begin
        bht[ex_bht_idx] <= ex_cnt - CNT_BITS'(1);
      end
      if (br_count != '1) br_count <= br_count + 32'd1;
      if (comp_o && (mispred_count != '1)) mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a queue-based scoreboard:
// stimulus pushes expected values, a negedge monitor pops and compares.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_IF = '0;
  logic        pred_taken_IF;
  logic [31:0] pred_target_IF;
  logic [6:0]  op_ex = '0;
  logic        stall_EX = 1'b0;
  logic [31:0] pc_EX = '0;
  logic        taken_EX = 1'b0;
  logic [31:0] target_EX = '0;
  logic        pred_taken_EX = 1'b0;
  logic [31:0] pred_target_EX = '0;
  logic        comp_o, flush_IF_ID, flush_ID_EX;
  logic [31:0] PC_jump_EX, br_count, mispred_count;

  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ALU  = 7'b0110011;

  branch_predict_unit #(
    .XLEN(32), .BHT_ENTRIES(64), .CNT_BITS(2), .BTB_ENTRIES(16), .TAG_W(10)
  ) dut (
    .clk(clk), .rst(rst), .pc_IF(pc_IF), .pred_taken_IF(pred_taken_IF),
    .pred_target_IF(pred_target_IF), .op_ex(op_ex), .stall_EX(stall_EX),
    .pc_EX(pc_EX), .taken_EX(taken_EX), .target_EX(target_EX),
    .pred_taken_EX(pred_taken_EX), .pred_target_EX(pred_target_EX),
    .comp_o(comp_o), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .PC_jump_EX(PC_jump_EX), .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "pred_taken_IF";
      1: return "pred_target_IF";
      2: return "comp_o";
      3: return "flush_IF_ID";
      4: return "flush_ID_EX";
      5: return "PC_jump_EX";
      6: return "br_count";
      default: return "mispred_count";
    endcase
  endfunction

  function automatic logic [31:0] sel_val(input int sel);
    case (sel)
      0: return {31'b0, pred_taken_IF};
      1: return pred_target_IF;
      2: return {31'b0, comp_o};
      3: return {31'b0, flush_IF_ID};
      4: return {31'b0, flush_ID_EX};
      5: return PC_jump_EX;
      6: return br_count;
      default: return mispred_count;
    endcase
  endfunction

  // Monitor: compare every expectation queued for the current cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.cyc < cyc) begin
        errors++;
        $display("FAIL %s stale expectation from cycle %0d required %h", sel_name(cur.sel), cur.cyc, cur.val);
      end else if (sel_val(cur.sel) !== cur.val) begin
        errors++;
        $display("FAIL %s cycle %0d got %h expected %h", sel_name(cur.sel), cyc, sel_val(cur.sel), cur.val);
      end
    end
  end

  task automatic expect_val(input int sel, input logic [31:0] val);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk_if(input logic tk, input logic [31:0] tgt);
    expect_val(0, {31'b0, tk});
    expect_val(1, tgt);
  endtask

  task automatic chk_res(input logic c, input logic [31:0] pj);
    expect_val(2, {31'b0, c});
    expect_val(3, {31'b0, c});
    expect_val(4, {31'b0, c});
    expect_val(5, pj);
  endtask

  task automatic chk_stats(input logic [31:0] b, input logic [31:0] m);
    expect_val(6, b);
    expect_val(7, m);
  endtask

  // Advance to just after the next rising edge, then drive a new cycle
  task automatic step(input logic r, input logic [31:0] pcif);
    @(posedge clk);
    #1;
    rst = r;
    pc_IF = pcif;
    stall_EX = 1'b0;
    op_ex = '0;
    taken_EX = 1'b0;
    pc_EX = '0;
    target_EX = '0;
    pred_taken_EX = 1'b0;
    pred_target_EX = '0;
  endtask

  task automatic ex(input logic [6:0] op, input logic [31:0] pce, input logic tk,
                    input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    op_ex = op;
    pc_EX = pce;
    taken_EX = tk;
    target_EX = tgt;
    pred_taken_EX = ptk;
    pred_target_EX = ptgt;
  endtask

  initial begin
    // Reset held: resolve forced off, PC_jump_EX = pc_EX+4
    step(1'b1, 32'h100);
    ex(BEQ, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    chk_if(1'b0, 32'h104); chk_res(1'b0, 32'h104); chk_stats(0, 0);

    step(1'b0, 32'h100);
    chk_if(1'b0, 32'h104); chk_stats(0, 0);

    // First taken BEQ: mispredicted; IF sees pre-update state
    step(1'b0, 32'h100);
    ex(BEQ, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    chk_res(1'b1, 32'h80); chk_if(1'b0, 32'h104); chk_stats(0, 0);

    step(1'b0, 32'h100);
    chk_if(1'b1, 32'h80); chk_stats(1, 1);

    // Five more correctly predicted takens saturate the counter
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h100);
      ex(BEQ, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      chk_res(1'b0, 32'h80); chk_stats(32'(1 + i), 1);
    end

    // Not-taken from saturated: mispredict, counter 3 -> 2
    step(1'b0, 32'h100);
    ex(BEQ, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    chk_res(1'b1, 32'h104); chk_stats(6, 1);

    step(1'b0, 32'h100);
    chk_if(1'b1, 32'h80); chk_stats(7, 2);

    // JALR right direction, wrong target; aliasing 0x200 misses the 0x100 tag
    step(1'b0, 32'h200);
    ex(JALR, 32'h200, 1'b0, 32'h340, 1'b1, 32'h300);
    chk_res(1'b1, 32'h340); chk_if(1'b0, 32'h204);

    step(1'b0, 32'h200);
    chk_if(1'b1, 32'h340); chk_stats(8, 3);

    // Not-taken 0x100 updates shared counter 3 -> 2 -> 1; lookup of 0x200 sees old value
    step(1'b0, 32'h200);
    ex(BEQ, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    chk_res(1'b0, 32'h104); chk_if(1'b1, 32'h340); chk_stats(8, 3);

    step(1'b0, 32'h200);
    ex(BEQ, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    chk_if(1'b1, 32'h340);

    step(1'b0, 32'h200);
    chk_if(1'b0, 32'h204); chk_stats(10, 3);

    // Stalled resolve: no flush, no training, no counting
    step(1'b0, 32'h200);
    ex(BEQ, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    stall_EX = 1'b1;
    chk_res(1'b0, 32'h80);

    step(1'b0, 32'h200);
    chk_if(1'b0, 32'h204); chk_stats(10, 3);

    // JAL with taken_EX low is still taken
    step(1'b0, 32'h40);
    ex(JAL, 32'h40, 1'b0, 32'h1000, 1'b0, 32'h44);
    chk_res(1'b1, 32'h1000);

    step(1'b0, 32'h40);
    chk_if(1'b1, 32'h1000); chk_stats(11, 4);

    // Non-control opcode never resolves
    step(1'b0, 32'h40);
    ex(ALU, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    expect_val(2, 32'h0);

    // Reset mid-stream with a pending mispredicted resolve
    step(1'b1, 32'h40);
    ex(BEQ, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    chk_if(1'b0, 32'h44); chk_res(1'b0, 32'h104); chk_stats(11, 4);

    step(1'b0, 32'h100);
    chk_if(1'b0, 32'h104); chk_stats(0, 0);

    step(1'b0, 32'h40);
    chk_if(1'b0, 32'h44);

    // PC+4 wraps modulo 2^32
    step(1'b0, 32'h100);
    ex(BEQ, 32'hFFFF_FFFC, 1'b0, 32'h80, 1'b0, 32'h0);
    chk_res(1'b0, 32'h0);

    step(1'b0, 32'h100);
    chk_stats(1, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain left %0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
